wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources.
- Source 1: the in-order pipeline's WB stage (fed by the MEM/WB pipeline register).
- Source 2: a long-latency unit (multi-cycle mul/div) that returns results out of band.
- Pipeline writes have priority. LU results are queued in a small FIFO and drained in free cycles. A starvation counter forces a one-cycle pipeline stall so that queued results always retire.

Parameters:
- DEPTH, 2, number of LU result buffer entries (power of two, ≥2).
- MAX_WAIT, 4, consecutive denied cycles of a non-empty buffer before a forced stall (≥1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- regwrite_WB  input  1  pipeline WB-stage write enable.
- rd_WB  input  5  pipeline WB destination register.
- wb_data_WB  input  32  pipeline WB write data (load/ALU select already applied).
- lu_valid  input  1  LU result valid.
- lu_rd  input  5  LU destination register.
- lu_data  input  32  LU result data.
- lu_ready  output  1  arbiter can accept an LU result.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  5  register-file write address.
- rf_wdata  output  32  register-file write data.
- stall_pipe  output  1  registered; freezes the pipeline, including the MEM/WB register, for this cycle.
- pend_mask  output  32  bit r = 1 while any buffered entry targets register r; consumed by the hazard/scoreboard unit.

Behaviour:
- Reset (reset_n low, asynchronous):
  - buffer empty; read/write pointers, count and wait_cnt = 0; stall_pipe = 0.
  - lu_ready = 1 once reset_n is high.
  - pend_mask = 0.
  - rf_we is forced to 0 while reset_n is low.
  - Assertion mid-operation discards all buffered entries without writing them.
- LU accept:
  - lu_ready = (count != DEPTH). It depends only on full; no pop-through when full.
  - A handshake completes when lu_valid && lu_ready.
  - If lu_rd == 0, the handshake completes and nothing is enqueued.
  - Otherwise {lu_rd, lu_data} is pushed at the tail at posedge.
- Grant (combinational each cycle; rf_* are sampled by the register file at the next posedge):
  - pipe_req = regwrite_WB && rd_WB != 0 && !stall_pipe.
  - If pipe_req: rf_we = 1, rf_waddr = rd_WB, rf_wdata = wb_data_WB.
  - Else if count != 0: pop the head. rf_we = 1, rf_waddr/rf_wdata = head entry. The pointer advances at posedge.
  - Else: rf_we = 0. rf_waddr and rf_wdata are don't-care; drive 0.
  - Writes to x0 from the pipeline never assert rf_we.
- Simultaneous push and pop in the same cycle: both take effect and count is unchanged. A push into an empty buffer is not visible at the head until the next cycle (minimum LU→RF latency is 1 cycle).
- Pointers wrap modulo DEPTH.
- Starvation:
  - wait_cnt increments each cycle with count != 0 and no pop. It clears on any pop or when the buffer is empty. It saturates at MAX_WAIT.
  - stall_pipe <= 1 at the posedge where wait_cnt == MAX_WAIT-1 and the current cycle is also denied.
  - stall_pipe is high for exactly one cycle, then returns to 0.
  - During a stall cycle the pipeline request is ignored, the head is popped and wait_cnt clears.
  - Contract: the pipeline holds its WB instruction across the stall and presents it again the following cycle, so no pipeline write is lost.
- pend_mask:
  - Computed as the OR over valid entries of the one-hot of rd.
  - Updates at the posedge following a push or pop.
  - Contract: the scoreboard forbids issuing any instruction that reads or writes a register set in pend_mask or targets an in-flight LU rd. The arbiter does not enforce WAW ordering.

Test Plan:
- Reset then idle: reset_n low 3 cycles mid-traffic with 2 entries buffered → count = 0, pend_mask = 0, rf_we = 0, lu_ready = 1 after release. No buffered write ever appears.
- Free-port drain: regwrite_WB = 0; push lu_rd = 5, lu_data = 0xDEAD_BEEF at cycle 0 → cycle 1: rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF; pend_mask bit 5 high for exactly cycle 1.
- Priority and full: regwrite_WB = 1, rd_WB = 3 every cycle; push rd 7 then rd 9 → rf_waddr = 3 each cycle; lu_ready = 0 after the 2nd push; a third lu_valid is held and not accepted.
- Starvation: continue the previous case (MAX_WAIT = 4) → stall_pipe = 1 in the 5th cycle after the first push, with rf_waddr = 7 that cycle. Next cycle the held rd 3 write occurs, then wait_cnt restarts for rd 9.
- x0 handling: lu_rd = 0 with lu_valid = 1 → lu_ready handshake completes, count unchanged. regwrite_WB = 1, rd_WB = 0 with a buffered entry → the buffer pops that cycle.
- Simultaneous push/pop at count = 1, then pointer wrap over 6 pushes → data is written in FIFO order (rd 1..6), and count never exceeds DEPTH.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline WB writes win, long-latency unit results
// wait in a small FIFO and are drained in free cycles, with a forced stall against starvation.
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        regwrite_WB,
    input  logic [4:0]  rd_WB,
    input  logic [31:0] wb_data_WB,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_pipe,
    output logic [31:0] pend_mask
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [WW-1:0] WMAX_C  = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WLAST_C = WW'(MAX_WAIT - 1);

    function automatic logic [31:0] onehot5(input logic [4:0] r);
        return 32'h0000_0001 << r;
    endfunction

    logic [4:0]       rd_q   [DEPTH];
    logic [4:0]       rd_d   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             stall_q, stall_d;
    logic [31:0]      pend_q, pend_d;
    logic             pipe_req_s, pop_s, push_s;

    assign lu_ready   = (count_q != FULL_C);
    assign stall_pipe = stall_q;
    assign pend_mask  = pend_q;

    // Request decode; reset_n gates the pipeline path so rf_we stays low during reset.
    always_comb begin
        pipe_req_s = reset_n && regwrite_WB && (rd_WB != 5'd0) && !stall_q;
        pop_s      = reset_n && !pipe_req_s && (count_q != {CW{1'b0}});
        push_s     = lu_valid && lu_ready && (lu_rd != 5'd0);
    end

    // Write-port mux: pipeline first, then FIFO head, otherwise idle.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (pipe_req_s) begin
            rf_we    = 1'b1;
            rf_waddr = rd_WB;
            rf_wdata = wb_data_WB;
        end else if (pop_s) begin
            rf_we    = 1'b1;
            rf_waddr = rd_q[rptr_q];
            rf_wdata = data_q[rptr_q];
        end else begin
            rf_we    = 1'b0;
        end
    end

    // Next-state for occupancy, starvation tracking and the pending-register mask.
    always_comb begin
        rd_d  = rd_q;
        vld_d = vld_q;
        if (pop_s) begin
            vld_d[rptr_q] = 1'b0;
        end else begin
            vld_d = vld_d;
        end
        if (push_s) begin
            vld_d[wptr_q] = 1'b1;
            rd_d[wptr_q]  = lu_rd;
        end else begin
            rd_d = rd_d;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
        // A denied non-empty buffer accumulates; the stall fires on the MAX_WAIT-th denial.
        if ((count_q != {CW{1'b0}}) && !pop_s) begin
            wait_d  = (wait_q == WMAX_C) ? WMAX_C : wait_q + WW'(1'b1);
            stall_d = (wait_q == WLAST_C);
        end else begin
            wait_d  = {WW{1'b0}};
            stall_d = 1'b0;
        end
        pend_d = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_d[i]) begin
                pend_d = pend_d | onehot5(rd_d[i]);
            end else begin
                pend_d = pend_d;
            end
        end
    end

    // State registers; reset discards every buffered entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= 5'd0;
                data_q[i] <= 32'd0;
            end
            vld_q   <= {DEPTH{1'b0}};
            wptr_q  <= {PW{1'b0}};
            rptr_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            wait_q  <= {WW{1'b0}};
            stall_q <= 1'b0;
            pend_q  <= 32'd0;
        end else begin
            rd_q    <= rd_d;
            vld_q   <= vld_d;
            count_q <= count_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            pend_q  <= pend_d;
            if (push_s) begin
                data_q[wptr_q] <= lu_data;
                wptr_q         <= wptr_q + PW'(1'b1);
            end
            if (pop_s) begin
                rptr_q <= rptr_q + PW'(1'b1);
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model, directed scenarios and random traffic.
module tb_wb_port_arbiter;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        regwrite_WB = 1'b0;
    logic [4:0]  rd_WB = 5'd0;
    logic [31:0] wb_data_WB = 32'd0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_rd = 5'd0;
    logic [31:0] lu_data = 32'd0;
    logic        lu_ready, rf_we, stall_pipe;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, pend_mask;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .regwrite_WB(regwrite_WB), .rd_WB(rd_WB), .wb_data_WB(wb_data_WB),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
        .lu_ready(lu_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_pipe(stall_pipe), .pend_mask(pend_mask)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   deny = 0;
    bit   m_stall = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    logic        obs_ready, obs_we, obs_stall;
    logic [4:0]  obs_a;
    logic [31:0] obs_d, obs_pm;
    bit          last_stall, last_acc;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare DUT against the model, then advance the model.
    task automatic step(input bit rstn, input bit rw, input logic [4:0] rd, input logic [31:0] wd,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        bit          preq, pop, push, e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d, e_pm;
        ent_t        e;
        @(negedge clk);
        reset_n = rstn; regwrite_WB = rw; rd_WB = rd; wb_data_WB = wd;
        lu_valid = lv; lu_rd = lrd; lu_data = ld;
        if (!rstn) begin
            q.delete(); deny = 0; m_stall = 1'b0;
        end
        #2;
        preq = rstn && rw && (rd != 5'd0) && !m_stall;
        pop  = rstn && !preq && (q.size() > 0);
        e_we = preq || pop;
        e_a  = preq ? rd : (pop ? q[0].rd : 5'd0);
        e_d  = preq ? wd : (pop ? q[0].d : 32'd0);
        e_pm = 32'd0;
        foreach (q[i]) e_pm[q[i].rd] = 1'b1;
        if (rstn) check("lu_ready", {31'd0, lu_ready}, {31'd0, q.size() < DEPTH});
        check("rf_we", {31'd0, rf_we}, {31'd0, e_we});
        check("rf_waddr", {27'd0, rf_waddr}, {27'd0, e_a});
        check("rf_wdata", rf_wdata, e_d);
        check("stall_pipe", {31'd0, stall_pipe}, {31'd0, m_stall});
        check("pend_mask", pend_mask, e_pm);
        obs_ready = lu_ready; obs_we = rf_we; obs_a = rf_waddr; obs_d = rf_wdata;
        obs_pm = pend_mask; obs_stall = stall_pipe;
        last_stall = m_stall;
        last_acc   = lv && (q.size() < DEPTH);
        push = last_acc && (lrd != 5'd0);
        @(posedge clk);
        if (rstn) begin
            if ((q.size() > 0) && !pop) deny++;
            else deny = 0;
            m_stall = (deny == MAX_WAIT);
            if (pop) void'(q.pop_front());
            if (push) begin
                e.rd = lrd; e.d = ld; q.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    bit          r_rst, r_rw, r_lv, hold_wb, hold_lu;
    logic [4:0]  r_rd, r_lrd;
    logic [31:0] r_wd, r_ld;
    int          bias;

    initial begin
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle(1);
        check("reset_ready", {31'd0, obs_ready}, 32'd1);
        check("reset_pend", obs_pm, 32'd0);

        // Free-port drain
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        check("drain_pend0", obs_pm, 32'd0);
        idle(1);
        check("drain_we", {31'd0, obs_we}, 32'd1);
        check("drain_addr", {27'd0, obs_a}, 32'd5);
        check("drain_data", obs_d, 32'hDEAD_BEEF);
        check("drain_pend1", obs_pm, 32'h0000_0020);
        idle(1);
        check("drain_pend2", obs_pm, 32'd0);

        // Priority, full and starvation
        idle(2);
        step(1'b1, 1'b1, 5'd3, 32'h3333_0000, 1'b1, 5'd7, 32'h7777_7777);
        check("prio_addr0", {27'd0, obs_a}, 32'd3);
        step(1'b1, 1'b1, 5'd3, 32'h3333_0001, 1'b1, 5'd9, 32'h9999_9999);
        check("prio_ready1", {31'd0, obs_ready}, 32'd1);
        for (int c = 2; c <= 4; c++) begin
            step(1'b1, 1'b1, 5'd3, 32'h3333_0000 + c, 1'b1, 5'd11, 32'hBBBB_BBBB);
            check("full_ready", {31'd0, obs_ready}, 32'd0);
            check("prio_addr", {27'd0, obs_a}, 32'd3);
        end
        step(1'b1, 1'b1, 5'd3, 32'h3333_0005, 1'b1, 5'd11, 32'hBBBB_BBBB);
        check("starve_stall", {31'd0, obs_stall}, 32'd1);
        check("starve_addr", {27'd0, obs_a}, 32'd7);
        check("starve_data", obs_d, 32'h7777_7777);
        step(1'b1, 1'b1, 5'd3, 32'h3333_0005, 1'b1, 5'd11, 32'hBBBB_BBBB);
        check("held_addr", {27'd0, obs_a}, 32'd3);
        check("held_stall", {31'd0, obs_stall}, 32'd0);
        check("held_ready", {31'd0, obs_ready}, 32'd1);
        for (int c = 7; c <= 10; c++) step(1'b1, 1'b1, 5'd3, 32'h3333_0006, 1'b0, 5'd0, 32'd0);
        check("starve2_stall", {31'd0, obs_stall}, 32'd1);
        check("starve2_addr", {27'd0, obs_a}, 32'd9);
        idle(4);

        // x0 handling
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234_5678);
        check("x0_ready", {31'd0, obs_ready}, 32'd1);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h4444_4444);
        check("x0_nowrite", {31'd0, obs_we}, 32'd0);
        step(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
        check("x0_pop_addr", {27'd0, obs_a}, 32'd4);
        check("x0_pop_data", obs_d, 32'h4444_4444);

        // Simultaneous push/pop with pointer wrap
        idle(2);
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'(k), 32'hA000_0000 + k);
            if (k > 1) check("wrap_addr", {27'd0, obs_a}, k - 1);
        end
        idle(1);
        check("wrap_last", {27'd0, obs_a}, 32'd6);

        // Reset mid-traffic with two entries buffered
        idle(2);
        step(1'b1, 1'b1, 5'd3, 32'd1, 1'b1, 5'd12, 32'hCCCC_0012);
        step(1'b1, 1'b1, 5'd3, 32'd2, 1'b1, 5'd13, 32'hCCCC_0013);
        check("pre_rst_pend", obs_pm, 32'h0000_1000);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 5'd3, 32'd3, 1'b1, 5'd14, 32'hCCCC_0014);
            check("rst_we", {31'd0, obs_we}, 32'd0);
            check("rst_pend", obs_pm, 32'd0);
        end
        idle(1);
        check("post_rst_ready", {31'd0, obs_ready}, 32'd1);
        check("post_rst_we", {31'd0, obs_we}, 32'd0);
        check("post_rst_pend", obs_pm, 32'd0);
        idle(2);

        // Random traffic under the hold contracts
        hold_wb = 1'b0; hold_lu = 1'b0;
        r_rw = 1'b0; r_rd = 5'd0; r_wd = 32'd0; r_lv = 1'b0; r_lrd = 5'd0; r_ld = 32'd0;
        for (int n = 0; n < 3000; n++) begin
            bias = ((n / 500) % 3 == 0) ? 90 : (((n / 500) % 3 == 1) ? 50 : 15);
            if (!hold_wb) begin
                r_rw = ($urandom_range(0, 99) < bias);
                r_rd = 5'($urandom_range(0, 31));
                r_wd = $urandom;
            end
            if (!hold_lu) begin
                r_lv  = ($urandom_range(0, 1) == 1);
                r_lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                r_ld  = $urandom;
            end
            r_rst = ($urandom_range(0, 199) != 0);
            step(r_rst, r_rw, r_rd, r_wd, r_lv, r_lrd, r_ld);
            hold_wb = r_rst && last_stall;
            hold_lu = r_rst && r_lv && !last_acc;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
